// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream packet generator with self-describing headers,
// programmable gaps and fixed / round-robin / LFSR destination selection.
`default_nettype none

module axis_traffic_gen #(
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 4,
  parameter int NUM_DESTS   = 4,
  parameter int MAX_PKT_LEN = 16,
  parameter int SRC_ID      = 0,
  parameter int SKIP_SELF   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            cfg_num_pkts,
  input  logic [7:0]             cfg_pkt_len,
  input  logic [7:0]             cfg_gap,
  input  logic [1:0]             cfg_dest_mode,
  input  logic [TDEST_WIDTH-1:0] cfg_dest,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            pkts_sent
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [15:0]            LFSR_SEED = 16'hACE1;
  localparam logic [7:0]             MAX_LEN   = 8'(MAX_PKT_LEN);
  localparam logic [7:0]             SRC_BYTE  = 8'(SRC_ID);
  localparam logic [15:0]            DEST_MASK = 16'(NUM_DESTS - 1);
  localparam logic [TDEST_WIDTH-1:0] LAST_DEST = TDEST_WIDTH'(NUM_DESTS - 1);
  localparam logic [TDEST_WIDTH-1:0] SELF_DEST = TDEST_WIDTH'(SRC_ID);
  localparam logic [TDEST_WIDTH-1:0] RR_FIRST  =
    TDEST_WIDTH'(((SKIP_SELF != 0) && (SRC_ID == 0)) ? 1 : 0);

  logic [1:0]             state;
  logic [15:0]            num_pkts_q;
  logic [7:0]             len_q;
  logic [7:0]             gap_q;
  logic [1:0]             mode_q;
  logic [TDEST_WIDTH-1:0] dest_q;
  logic [15:0]            seq;
  logic [TDEST_WIDTH-1:0] rr_ptr;
  logic [15:0]            lfsr;
  logic                   stop_req;
  logic [7:0]             beat;
  logic [7:0]             gap_cnt;

  function automatic logic [TDATA_WIDTH-1:0] header_word(input logic [15:0] s,
                                                         input logic [7:0] len);
    logic [TDATA_WIDTH-1:0] d;
    d       = '0;
    d[31:0] = {SRC_BYTE, len, s};
    return d;
  endfunction

  function automatic logic [TDATA_WIDTH-1:0] payload_word(input logic [15:0] s,
                                                          input logic [7:0] k);
    logic [TDATA_WIDTH-1:0] d;
    d       = '0;
    d[31:0] = {s, 8'd0, k};
    return d;
  endfunction

  function automatic logic [TDEST_WIDTH-1:0] rr_inc(input logic [TDEST_WIDTH-1:0] p);
    return (p == LAST_DEST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [TDEST_WIDTH-1:0] rr_step(input logic [TDEST_WIDTH-1:0] p);
    logic [TDEST_WIDTH-1:0] n;
    n = rr_inc(p);
    if ((SKIP_SELF != 0) && (n == SELF_DEST)) n = rr_inc(n);
    return n;
  endfunction

  logic [7:0]  eff_len_in;
  logic        handshake;
  logic        last_hs;
  logic [31:0] sent_next;
  logic        run_end;
  logic        gap_end;
  logic [15:0] lfsr_next;
  logic        launch;

  always_comb begin
    eff_len_in = cfg_pkt_len;
    if (cfg_pkt_len == 8'd0)       eff_len_in = 8'd1;
    else if (cfg_pkt_len > MAX_LEN) eff_len_in = MAX_LEN;
  end

  assign handshake = axis_out_tvalid & axis_out_tready;
  assign last_hs   = handshake & axis_out_tlast;
  assign sent_next = pkts_sent + 32'd1;
  // A stop arriving with the final handshake still ends the run after this packet.
  assign run_end   = ((num_pkts_q != 16'd0) && (sent_next == {16'd0, num_pkts_q}))
                     || stop_req || stop;
  assign gap_end   = (state == S_GAP) && (gap_cnt <= 8'd1);
  // Fibonacci form, taps 16/14/13/11, shifting towards bit 0.
  assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  assign launch = ((state == S_IDLE) && start)
               || ((state == S_SEND) && last_hs && !run_end && (gap_q == 8'd0))
               || (gap_end && !(stop_req || stop));

  // Values for the header of the packet about to be presented.
  logic [15:0]            l_seq;
  logic [7:0]             l_len;
  logic [1:0]             l_mode;
  logic [TDEST_WIDTH-1:0] l_fix;
  logic [TDEST_WIDTH-1:0] l_rr;
  logic [15:0]            l_lfsr;
  logic [TDEST_WIDTH-1:0] l_dest;

  always_comb begin
    l_seq  = seq;
    l_len  = len_q;
    l_mode = mode_q;
    l_fix  = dest_q;
    l_rr   = rr_ptr;
    l_lfsr = lfsr;
    case (state)
      S_IDLE: begin
        l_seq  = 16'd0;
        l_len  = eff_len_in;
        l_mode = cfg_dest_mode;
        l_fix  = cfg_dest;
        l_rr   = RR_FIRST;
        l_lfsr = LFSR_SEED;
      end
      S_SEND: begin
        l_seq  = seq + 16'd1;
        l_lfsr = lfsr_next;
      end
      default: ;
    endcase
    case (l_mode)
      2'd1:    l_dest = l_rr;
      2'd2:    l_dest = TDEST_WIDTH'(l_lfsr & DEST_MASK);
      default: l_dest = l_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      num_pkts_q      <= '0;
      len_q           <= 8'd1;
      gap_q           <= '0;
      mode_q          <= '0;
      dest_q          <= '0;
      seq             <= '0;
      rr_ptr          <= '0;
      lfsr            <= LFSR_SEED;
      stop_req        <= 1'b0;
      beat            <= '0;
      gap_cnt         <= '0;
      axis_out_tvalid <= 1'b0;
      axis_out_tdata  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tdest  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pkts_sent       <= '0;
    end else begin
      done <= 1'b0;
      if (stop && (state != S_IDLE)) stop_req <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            num_pkts_q <= cfg_num_pkts;
            len_q      <= eff_len_in;
            gap_q      <= cfg_gap;
            mode_q     <= cfg_dest_mode;
            dest_q     <= cfg_dest;
            seq        <= 16'd0;
            pkts_sent  <= '0;
            stop_req   <= 1'b0;
            lfsr       <= LFSR_SEED;
            busy       <= 1'b1;
            state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (handshake) begin
            if (!axis_out_tlast) begin
              beat           <= beat + 8'd1;
              axis_out_tdata <= payload_word(seq, beat + 8'd1);
              axis_out_tlast <= ((beat + 8'd2) == len_q);
            end else begin
              pkts_sent <= sent_next;
              seq       <= seq + 16'd1;
              lfsr      <= lfsr_next;
              if (run_end) begin
                axis_out_tvalid <= 1'b0;
                axis_out_tlast  <= 1'b0;
                busy            <= 1'b0;
                done            <= 1'b1;
                state           <= S_FINISH;
              end else if (gap_q != 8'd0) begin
                axis_out_tvalid <= 1'b0;
                axis_out_tlast  <= 1'b0;
                gap_cnt         <= gap_q;
                state           <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_end) begin
            if (stop_req || stop) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              state <= S_SEND;
            end
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (launch) begin
        axis_out_tvalid <= 1'b1;
        axis_out_tdata  <= header_word(l_seq, l_len);
        axis_out_tlast  <= (l_len == 8'd1);
        axis_out_tdest  <= l_dest;
        rr_ptr          <= rr_step(l_rr);
        beat            <= 8'd0;
      end
    end
  end

endmodule

`default_nettype wire
